// File: rtl/disp_pkg.sv
// Shared widths and scheduler state encoding for the display character-memory write path.
package disp_pkg;

  localparam int DISP_ADR_W = 7;
  localparam int DISP_D_W   = 4;
  localparam int WR_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } disp_st_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered "last granted" pointer.
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic vld0_i,
  input  logic vld1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  // last_q = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  logic last_q, last_d;

  always_comb begin
    gnt0_o = en_i & vld0_i & (~vld1_i | last_q);
    gnt1_o = en_i & vld1_i & (~vld0_i | ~last_q);
    last_d = last_q;
    if (gnt0_o) begin
      last_d = 1'b0;
    end else if (gnt1_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/disp_wr_sched.sv
// Round-robin write scheduler for the display character memory; optionally confines
// writes to vertical blanking with a per-window write limit.
module disp_wr_sched
  import disp_pkg::*;
#(
  parameter int MAX_PER_FRAME = 128,
  parameter bit BLANK_ONLY    = 1'b1
) (
  input  logic                  disp_clk,
  input  logic                  rst_disp,
  input  logic                  i_sync_va,
  input  logic                  i_req0_vld,
  input  logic [DISP_ADR_W-1:0] i_req0_adr,
  input  logic [DISP_D_W-1:0]   i_req0_d,
  output logic                  o_req0_rdy,
  input  logic                  i_req1_vld,
  input  logic [DISP_ADR_W-1:0] i_req1_adr,
  input  logic [DISP_D_W-1:0]   i_req1_d,
  output logic                  o_req1_rdy,
  output logic                  o_disp_wen,
  output logic                  o_disp_men,
  output logic [DISP_ADR_W-1:0] o_disp_adr,
  output logic [DISP_D_W-1:0]   o_disp_d,
  output logic                  o_frame_done,
  output logic [WR_CNT_W-1:0]   o_wr_cnt
);

  localparam logic [WR_CNT_W-1:0] MAX_C = WR_CNT_W'(MAX_PER_FRAME);

  disp_st_e              state_q, state_d;
  logic                  va_q;
  logic [WR_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic                  fd_q, fd_d;
  logic                  wen_q;
  logic [DISP_ADR_W-1:0] adr_q;
  logic [DISP_D_W-1:0]   d_q;
  logic                  bs, win_ok, arb_en, gnt0, gnt1, xfer;

  assign bs = va_q & ~i_sync_va;

  // Readiness is withheld during reset so a requester never sees a transfer that is dropped.
  always_comb begin
    if (BLANK_ONLY) begin
      win_ok = (state_q == ST_WRITE) & ~i_sync_va & (cnt_q < MAX_C);
    end else begin
      win_ok = 1'b1;
    end
    arb_en = win_ok & ~rst_disp;
  end

  rr_arb2 u_arb (
    .clk_i  (disp_clk),
    .rst_i  (rst_disp),
    .en_i   (arb_en),
    .vld0_i (i_req0_vld),
    .vld1_i (i_req1_vld),
    .gnt0_o (gnt0),
    .gnt1_o (gnt1)
  );

  assign xfer       = gnt0 | gnt1;
  assign o_req0_rdy = gnt0;
  assign o_req1_rdy = gnt1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fd_d    = 1'b0;
    cnt_inc = (cnt_q == {WR_CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    if (!BLANK_ONLY) begin
      state_d = ST_WRITE;
      if (xfer) cnt_d = cnt_inc;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bs) begin
            state_d = ST_WRITE;
            cnt_d   = '0;
          end
        end
        ST_WRITE: begin
          if (xfer) cnt_d = cnt_inc;
          if (i_sync_va) begin
            state_d = ST_IDLE;
            fd_d    = 1'b1;
          end else if (xfer && (cnt_inc == MAX_C)) begin
            state_d = ST_DONE;
            fd_d    = 1'b1;
          end
        end
        ST_DONE: begin
          if (i_sync_va) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge disp_clk) begin
    if (rst_disp) begin
      state_q <= ST_IDLE;
      va_q    <= 1'b1;
      cnt_q   <= '0;
      fd_q    <= 1'b0;
      wen_q   <= 1'b0;
      adr_q   <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      va_q    <= i_sync_va;
      cnt_q   <= cnt_d;
      fd_q    <= fd_d;
      wen_q   <= xfer;
      if (xfer) begin
        adr_q <= gnt1 ? i_req1_adr : i_req0_adr;
        d_q   <= gnt1 ? i_req1_d : i_req0_d;
      end
    end
  end

  assign o_disp_wen   = wen_q;
  assign o_disp_men   = wen_q;
  assign o_disp_adr   = adr_q;
  assign o_disp_d     = d_q;
  assign o_frame_done = fd_q;
  assign o_wr_cnt     = cnt_q;

endmodule

// File: tb/tb_disp_wr_sched.sv
// Scoreboard bench for disp_wr_sched: random frames and requesters against a window/round-robin model.
module tb_disp_wr_sched;

  localparam int MAXW = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       va  = 1'b1;
  logic       v0  = 1'b0, v1 = 1'b0;
  logic [6:0] a0  = '0, a1 = '0, oadr;
  logic [3:0] d0  = '0, d1 = '0, od;
  logic       r0, r1, wen, men, fd;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  disp_wr_sched #(.MAX_PER_FRAME(MAXW), .BLANK_ONLY(1'b1)) dut (
    .disp_clk     (clk),
    .rst_disp     (rst),
    .i_sync_va    (va),
    .i_req0_vld   (v0),
    .i_req0_adr   (a0),
    .i_req0_d     (d0),
    .o_req0_rdy   (r0),
    .i_req1_vld   (v1),
    .i_req1_adr   (a1),
    .i_req1_d     (d1),
    .o_req1_rdy   (r1),
    .o_disp_wen   (wen),
    .o_disp_men   (men),
    .o_disp_adr   (oadr),
    .o_disp_d     (od),
    .o_frame_done (fd),
    .o_wr_cnt     (cnt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [10:0] wq[$];
  logic [10:0] mon_e;

  // Reference model: window open/exhausted flags, writes this window, who wins the next tie.
  bit m_prev_va = 1'b1, m_in_win = 1'b0, m_exh = 1'b0, m_pref1 = 1'b0;
  int m_cnt = 0;
  bit e_wen = 1'b0, e_fd = 1'b0;
  logic [6:0] e_adr = '0;
  logic [3:0] e_d = '0;
  int e_cnt = 0;
  int p0 = 0, p1 = 0;
  bit dut_x0 = 1'b0, dut_x1 = 1'b0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endfunction

  // Write monitor: every display write must match the oldest granted request.
  always @(negedge clk) begin
    if (wen === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write cyc=%0d got_adr=%0h want=none", cyc, oadr);
      end else begin
        mon_e = wq.pop_front();
        chk("wr_adr", int'(oadr), int'(mon_e[10:4]));
        chk("wr_d", int'(od), int'(mon_e[3:0]));
        chk("wr_men", int'(men), 1);
      end
    end
  end

  task automatic step(input bit va_in, input bit rst_in);
    bit bs, allow, er0, er1;
    @(negedge clk);
    #2;
    chk("wen", int'(wen), int'(e_wen));
    chk("frame_done", int'(fd), int'(e_fd));
    chk("wr_cnt", int'(cnt), e_cnt);
    chk("adr_hold", int'(oadr), int'(e_adr));
    chk("d_hold", int'(od), int'(e_d));
    if (dut_x0) v0 = 1'b0;
    if (dut_x1) v1 = 1'b0;
    if (!v0 && ($urandom_range(99) < p0)) begin
      v0 = 1'b1; a0 = 7'($urandom); d0 = 4'($urandom);
    end
    if (!v1 && ($urandom_range(99) < p1)) begin
      v1 = 1'b1; a1 = 7'($urandom); d1 = 4'($urandom);
    end
    va  = va_in;
    rst = rst_in;
    #1;
    if (rst_in) begin
      er0 = 1'b0; er1 = 1'b0;
    end else begin
      bs    = m_prev_va & ~va_in;
      allow = m_in_win & ~va_in & (m_cnt < MAXW);
      er0   = allow & v0 & (~v1 | ~m_pref1);
      er1   = allow & v1 & (~v0 | m_pref1);
    end
    chk("rdy0", int'(r0), int'(er0));
    chk("rdy1", int'(r1), int'(er1));
    chk("one_rdy", int'(r0 & r1), 0);
    dut_x0 = v0 & r0;
    dut_x1 = v1 & r1;
    if (rst_in) begin
      m_prev_va = 1'b1; m_in_win = 1'b0; m_exh = 1'b0; m_pref1 = 1'b0; m_cnt = 0;
      e_wen = 1'b0; e_fd = 1'b0; e_adr = '0; e_d = '0; e_cnt = 0;
    end else begin
      e_wen = er0 | er1;
      e_fd  = 1'b0;
      if (er0) begin
        wq.push_back({a0, d0}); e_adr = a0; e_d = d0; m_cnt++; m_pref1 = 1'b1;
      end else if (er1) begin
        wq.push_back({a1, d1}); e_adr = a1; e_d = d1; m_cnt++; m_pref1 = 1'b0;
      end
      if (m_in_win) begin
        if (va_in) begin
          m_in_win = 1'b0; e_fd = 1'b1;
        end else if (m_cnt == MAXW) begin
          m_in_win = 1'b0; m_exh = 1'b1; e_fd = 1'b1;
        end
      end else if (m_exh) begin
        if (va_in) m_exh = 1'b0;
      end else if (bs) begin
        m_in_win = 1'b1; m_cnt = 0;
      end
      e_cnt     = m_cnt;
      m_prev_va = va_in;
    end
    cyc++;
  endtask

  task automatic frame(input int vis, input int blk, input int rst_at);
    for (int i = 0; i < vis; i++) step(1'b1, 1'b0);
    for (int i = 0; i < blk; i++) step(1'b0, i == rst_at);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    // Held request during visible lines, then a single write in blanking.
    v0 = 1'b1; a0 = 7'h15; d0 = 4'h9;
    frame(5, 4, -1);
    // Both requesters saturated: alternating grants, window limit reached twice.
    p0 = 100; p1 = 100;
    frame(4, 10, -1);
    frame(4, 10, -1);
    // Short window closes while req1 is still pending; next blank grants it.
    p0 = 0;
    frame(4, 2, -1);
    p1 = 0;
    frame(4, 4, -1);
    // Reset mid-window with blanking continuing afterwards.
    p0 = 100; p1 = 50;
    frame(4, 8, 2);
    for (int f = 0; f < 40; f++) begin
      p0 = $urandom_range(100);
      p1 = $urandom_range(100);
      frame($urandom_range(3, 8), $urandom_range(1, 10), (f % 13 == 5) ? $urandom_range(0, 3) : -1);
    end
    p0 = 0; p1 = 0;
    frame(4, 0, -1);
    chk("queue_drained", wq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_wr_sched.md
# disp_wr_sched

Write scheduler for the display character memory port (`wen`/`men`/7-bit address/4-bit data) feeding `disp_digit`. It arbitrates round-robin between two requesters, typically board-update logic (req0) and score/next-piece logic (req1). With `BLANK_ONLY=1` it issues writes only during vertical blanking, so a frame never shows a half-updated board. It sits between game logic and `display`, and is clocked by `disp_clk`.

## Interface
Parameters:
- `MAX_PER_FRAME`, 128: maximum writes granted per blanking window, range 1..255.
- `BLANK_ONLY`, 1: 1 gates writes to vertical blanking; 0 grants writes any cycle, with no window and no limit.

Ports:
- `disp_clk`  in  1  display clock; the only clock.
- `rst_disp`  in  1  reset, synchronous, active-high.
- `i_sync_va`  in  1  vertical active from `sync_gen` (1 = visible lines).
- `i_req0_vld`  in  1  requester 0 write valid.
- `i_req0_adr`  in  7  requester 0 address.
- `i_req0_d`  in  4  requester 0 data.
- `o_req0_rdy`  out  1  requester 0 accept.
- `i_req1_vld`, `i_req1_adr`, `i_req1_d`, `o_req1_rdy`: same as requester 0, for requester 1.
- `o_disp_wen`  out  1  write enable to display.
- `o_disp_men`  out  1  memory enable to display.
- `o_disp_adr`  out  7  write address.
- `o_disp_d`  out  4  write data.
- `o_frame_done`  out  1  one-cycle pulse when a write window closes.
- `o_wr_cnt`  out  8  writes issued in the current or most recent window.

## Operation
- Transfer rule: a transfer occurs on requester N when `i_reqN_vld & o_reqN_rdy` in the same cycle.
  - The requester holds `vld`, `adr` and `d` stable until the transfer.
  - `vld` does not depend on `rdy`.
- `o_reqN_rdy` is combinational from the state, the grant pointer, `i_sync_va` and both `vld` inputs. At most one `rdy` is high per cycle.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last is granted.
  - `last` pointer resets to 1, so req0 wins the first tie. `last` updates only on a transfer.
- Edge detection: `va_q` registers `i_sync_va`. `va_q` resets to 1. Blank start `bs = va_q & ~i_sync_va`.
- FSM when `BLANK_ONLY=1`:
  - IDLE: `rdy` = 0. On `bs`, go to WRITE and clear `o_wr_cnt`.
  - WRITE: `rdy` is allowed only while `i_sync_va == 0` and `o_wr_cnt < MAX_PER_FRAME`.
    - On `i_sync_va == 1`, go to IDLE.
    - On the transfer that makes the count equal `MAX_PER_FRAME`, go to DONE.
    - Either exit pulses `o_frame_done` for one cycle.
  - DONE: `rdy` = 0. On `i_sync_va == 1`, go to IDLE. No second window opens in the same blanking period.
- `BLANK_ONLY=0`:
  - The FSM stays in WRITE.
  - `i_sync_va` and `MAX_PER_FRAME` are ignored.
  - `o_frame_done` stays 0.
  - `o_wr_cnt` saturates at 255.
- `o_wr_cnt` increments once per transfer and holds its value after the window closes.
- Reset values: state IDLE, `last` = 1, `va_q` = 1, `o_wr_cnt` = 0. All outputs 0.
- Reset during blanking: `va_q` = 1 with `i_sync_va` = 0 produces `bs` on the first cycle out of reset, so a window opens.
- Reset mid-window: the window is abandoned immediately; no write is issued on the next cycle.

## Timing
- Write latency is 1 cycle. Transfer in cycle T gives registered `o_disp_wen = o_disp_men = 1` in T+1, with the granted `adr` and `d`.
- `o_disp_wen`/`o_disp_men` are single-cycle pulses per transfer. Back-to-back transfers give a continuous run of pulses.
- `o_disp_adr`/`o_disp_d` hold their last value when no write is issued.
- Window open: `i_sync_va` falls at cycle N; `bs` is seen at N; `rdy` is allowed from N+1.
- Window close: `i_sync_va` rises at cycle M; `rdy` is 0 in M combinationally, so there is no transfer at M; state is IDLE at M+1; `o_frame_done` = 1 at M+1.
- Limit close: the final transfer is at cycle K; `o_frame_done` = 1 at K+1; state is DONE at K+1.

## Structure
- Shared package `disp_pkg`: `DISP_ADR_W` = 7, `DISP_D_W` = 4, and the FSM state encoding `ST_IDLE`/`ST_WRITE`/`ST_DONE`.
- One sub-module, `rr_arb2`: 2-way round-robin arbiter with combinational grant and registered `last` pointer, updated on transfer.
- FSM, counter and output register stay in `disp_wr_sched`.

## Test plan
- **Single write in blanking.** Drop `i_sync_va`; assert req0 `adr=0x15`, `d=0x9`. Required: `rdy0` high at N+1; `o_disp_wen = o_disp_men = 1`, `adr=0x15`, `d=0x9` one cycle after the transfer; `o_wr_cnt = 1`.
- **Contention.** Hold both requesters valid for 4 transfers. Required: grant order req0, req1, req0, req1; never both `rdy` high in one cycle.
- **Frame limit.** Set `MAX_PER_FRAME = 3`; req0 valid through a 10-cycle blank. Required: exactly 3 writes; `o_frame_done` one cycle after the 3rd; `rdy` = 0 until the next blank.
- **Window close.** `i_sync_va` rises while req1 is valid. Required: no transfer in the rising cycle; `o_frame_done` at M+1; the held request is granted in the next blank.
- **Visible-period requests.** Requests during visible lines with `BLANK_ONLY = 1`. Required: `rdy` = 0 and no `o_disp_wen`.
- **Mid-window reset.** Assert `rst_disp` mid-window. Required: all outputs 0 the next cycle. After release during blanking, a new window opens with `o_wr_cnt` restarting from 0.
